// File: rtl/spi_minion_pkg.sv
// Shared frame geometry and FSM encodings for the SPI minion front end.
package spi_minion_pkg;

  localparam int unsigned DATA_BITS_DEFAULT = 32;

  // Frame = {val, spc, payload}
  function automatic int unsigned frame_bits(input int unsigned data_bits);
    return data_bits + 2;
  endfunction

  function automatic int unsigned val_bit(input int unsigned data_bits);
    return data_bits + 1;
  endfunction

  function automatic int unsigned spc_bit(input int unsigned data_bits);
    return data_bits;
  endfunction

  localparam int unsigned VAL_BIT = val_bit(DATA_BITS_DEFAULT);
  localparam int unsigned SPC_BIT = spc_bit(DATA_BITS_DEFAULT);

  // FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/spi_minion_frontend_if.sv
// Receive/send stream between the SPI front end and the minion adapter.
// master = front-end side (drives recv stream), slave = adapter side.
interface spi_minion_frontend_if #(
  parameter int unsigned DATA_BITS = 32
);
  logic [DATA_BITS-1:0] recv_msg;
  logic                 recv_val;
  logic                 recv_rdy;
  logic [DATA_BITS-1:0] send_msg;
  logic                 send_val;
  logic                 send_rdy;
  logic                 minion_parity;

  modport master (
    output recv_msg, recv_val, send_rdy, minion_parity,
    input  recv_rdy, send_msg, send_val
  );

  modport slave (
    input  recv_msg, recv_val, send_rdy, minion_parity,
    output recv_rdy, send_msg, send_val
  );
endinterface

// File: rtl/spi_minion_sync.sv
// Two-flop synchronizer with configurable reset value and a delayed copy
// of the synchronized signal for edge detection.
module spi_minion_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic dly_o
);
  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Synchronizer chain followed by the edge-detect delay flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign dly_o  = dly_q;
endmodule

// File: rtl/spi_minion_frontend.sv
// SPI mode-0 minion front end: synchronizes the SPI pins, deserializes
// fixed-length frames into a valid/ready stream and serializes the reply.
module spi_minion_frontend
  import spi_minion_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spi_min_cs,
  input  logic                   spi_min_sclk,
  input  logic                   spi_min_mosi,
  output logic                   spi_min_miso,
  spi_minion_frontend_if.master  bus
);
  localparam int unsigned NBITS = frame_bits(DATA_BITS);
  localparam int unsigned VAL_B = val_bit(DATA_BITS);
  localparam int unsigned SPC_B = spc_bit(DATA_BITS);
  localparam int unsigned CNT_W = $clog2(NBITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NBITS + 1);

  logic cs_s, cs_d, sclk_s, sclk_d, mosi_s, mosi_dly_unused;

  spi_minion_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(reset), .async_i(spi_min_cs), .sync_o(cs_s), .dly_o(cs_d)
  );
  spi_minion_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(reset), .async_i(spi_min_sclk), .sync_o(sclk_s), .dly_o(sclk_d)
  );
  spi_minion_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(reset), .async_i(spi_min_mosi), .sync_o(mosi_s), .dly_o(mosi_dly_unused)
  );

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NBITS-1:0]     tx_q, tx_d;
  logic [NBITS-1:0]     rx_q, rx_d;
  logic                 snap_val_q, snap_val_d;
  logic                 adv_spc_q, adv_spc_d;
  logic [DATA_BITS-1:0] recv_msg_q, recv_msg_d;
  logic                 recv_val_q, recv_val_d;
  logic                 send_rdy_q, send_rdy_d;
  logic                 parity_q, parity_d;

  // Frame FSM, shift registers, receive buffer and handshake generation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    snap_val_d = snap_val_q;
    adv_spc_d  = adv_spc_q;
    recv_msg_d = recv_msg_q;
    recv_val_d = recv_val_q;
    send_rdy_d = 1'b0;
    parity_d   = parity_q;

    if (recv_val_q && bus.recv_rdy) begin
      recv_val_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          tx_d       = {bus.send_val, ~recv_val_q, bus.send_msg};
          snap_val_d = bus.send_val;
          adv_spc_d  = ~recv_val_q;
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // sclk edges in the same cycle as cs rising are still consumed
        if (sclk_rise) begin
          rx_d = {rx_q[NBITS-2:0], mosi_s};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (sclk_fall) begin
          tx_d = {tx_q[NBITS-2:0], 1'b0};
        end
        if (cs_rise) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (cnt_q == CNT_FULL) begin
          // load wins over a coincident handshake clear
          if (rx_q[VAL_B] && adv_spc_q) begin
            recv_msg_d = rx_q[DATA_BITS-1:0];
            recv_val_d = 1'b1;
            parity_d   = ^rx_q[DATA_BITS-1:0];
          end
          if (rx_q[SPC_B] && snap_val_q) begin
            send_rdy_d = 1'b1;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      snap_val_q <= 1'b0;
      adv_spc_q  <= 1'b0;
      recv_msg_q <= '0;
      recv_val_q <= 1'b0;
      send_rdy_q <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      snap_val_q <= snap_val_d;
      adv_spc_q  <= adv_spc_d;
      recv_msg_q <= recv_msg_d;
      recv_val_q <= recv_val_d;
      send_rdy_q <= send_rdy_d;
      parity_q   <= parity_d;
    end
  end

  assign spi_min_miso      = tx_q[NBITS-1];
  assign bus.recv_msg      = recv_msg_q;
  assign bus.recv_val      = recv_val_q;
  assign bus.send_rdy      = send_rdy_q;
  assign bus.minion_parity = parity_q;
endmodule

// File: tb/tb_spi_minion_frontend.sv
// Scoreboard bench for spi_minion_frontend: stimulus pushes expected
// deliveries, send handshakes and miso frames; monitors pop and compare.
module tb_spi_minion_frontend;
  localparam int unsigned DB = 32;
  localparam int unsigned NB = DB + 2;

  logic clk = 1'b0;
  logic reset;
  logic cs, sclk, mosi;
  logic miso;

  spi_minion_frontend_if #(.DATA_BITS(DB)) bus ();

  spi_minion_frontend #(.DATA_BITS(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_min_cs   (cs),
    .spi_min_sclk (sclk),
    .spi_min_mosi (mosi),
    .spi_min_miso (miso),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] msg;
    logic          par;
  } recv_t;

  recv_t         exp_recv[$];
  logic          exp_send[$];
  logic [NB-1:0] exp_miso[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive at 1 time unit after the rising edge
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [39:0] bits, input int nbits, input int h);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = bits[i];
      wait_clk(h);
      sclk = 1'b1;
      wait_clk(h);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [39:0] bits, input int nbits, input int h);
    cs = 1'b0;
    spi_bits(bits, nbits, h);
    wait_clk(h);
    cs = 1'b1;
    wait_clk(3);
  endtask

  task automatic frame(input logic v, input logic s, input logic [DB-1:0] p, input int h);
    spi_xfer({6'b0, v, s, p}, NB, h);
  endtask

  task automatic expect_recv(input logic [DB-1:0] m, input logic p);
    exp_recv.push_back('{msg: m, par: p});
  endtask

  task automatic expect_miso(input logic v, input logic s, input logic [DB-1:0] p);
    exp_miso.push_back({v, s, p});
  endtask

  // Receive-stream monitor
  always @(negedge clk) begin
    if (!reset && bus.recv_val && bus.recv_rdy) begin
      if (exp_recv.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL recv_unexpected: got msg %h, expected no delivery", bus.recv_msg);
      end else begin
        recv_t e;
        e = exp_recv.pop_front();
        check("recv_msg", 64'(bus.recv_msg), 64'(e.msg));
        check("recv_parity", 64'(bus.minion_parity), 64'(e.par));
      end
    end
  end

  // Send-handshake monitor
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (!reset && bus.send_rdy) begin
      check("send_rdy_width", 64'(prev_rdy), 64'd0);
      if (exp_send.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_unexpected: got send_rdy=1, expected 0");
      end else begin
        void'(exp_send.pop_front());
      end
    end
    prev_rdy <= bus.send_rdy;
  end

  // miso frame monitor: master samples on sclk rising
  logic [NB-1:0] cap = '0;
  int            ncap = 0;
  always @(posedge sclk) begin
    if (!cs) begin
      cap  <= {cap[NB-2:0], miso};
      ncap <= ncap + 1;
    end
  end
  always @(negedge cs) ncap <= 0;
  always @(posedge cs) begin
    if (ncap == int'(NB)) begin
      if (exp_miso.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL miso_unexpected: got %h, expected no checked frame", cap);
      end else begin
        check("miso_frame", 64'(cap), 64'(exp_miso.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    bus.recv_rdy = 1'b0; bus.send_val = 1'b0; bus.send_msg = '0;
    wait_clk(3);
    check("rst_miso", 64'(miso), 64'd0);
    check("rst_recv_val", 64'(bus.recv_val), 64'd0);
    check("rst_recv_msg", 64'(bus.recv_msg), 64'd0);
    check("rst_send_rdy", 64'(bus.send_rdy), 64'd0);
    check("rst_parity", 64'(bus.minion_parity), 64'd0);
    reset = 1'b0;
    wait_clk(3);

    // Reset in the middle of a frame
    bus.send_val = 1'b1; bus.send_msg = 32'hFFFF_FFFF;
    cs = 1'b0;
    spi_bits(40'h00_FFFF_FFFF, 10, 4);
    reset = 1'b1;
    #1;
    check("midrst_miso", 64'(miso), 64'd0);
    check("midrst_recv_val", 64'(bus.recv_val), 64'd0);
    check("midrst_send_rdy", 64'(bus.send_rdy), 64'd0);
    check("midrst_parity", 64'(bus.minion_parity), 64'd0);
    cs = 1'b1; sclk = 1'b0;
    bus.send_val = 1'b0; bus.send_msg = '0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);

    // Full frame after reset
    bus.recv_rdy = 1'b1;
    expect_recv(32'hDEAD_BEEF, 1'b0);
    expect_miso(1'b0, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'hDEAD_BEEF, 4);
    wait_clk(6);
    check("deadbeef_msg", 64'(bus.recv_msg), 64'hDEAD_BEEF);
    check("deadbeef_parity", 64'(bus.minion_parity), 64'd0);

    // Single-bit payload, parity 1
    expect_recv(32'h0000_0001, 1'b1);
    expect_miso(1'b0, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_0001, 4);
    wait_clk(6);
    check("one_parity", 64'(bus.minion_parity), 64'd1);

    // Minion send path
    bus.send_val = 1'b1; bus.send_msg = 32'hCAFE_F00D;
    exp_send.push_back(1'b1);
    expect_miso(1'b1, 1'b1, 32'hCAFE_F00D);
    frame(1'b0, 1'b1, 32'h0, 4);
    wait_clk(6);
    bus.send_val = 1'b0; bus.send_msg = '0;
    check("send_no_recv", 64'(bus.recv_val), 64'd0);

    // Buffer full: second frame sees spc=0 and is dropped
    bus.recv_rdy = 1'b0;
    expect_miso(1'b0, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h1111_1111, 4);
    wait_clk(6);
    expect_miso(1'b0, 1'b0, 32'h0);
    frame(1'b1, 1'b1, 32'h2222_2222, 4);
    wait_clk(6);
    check("full_recv_val", 64'(bus.recv_val), 64'd1);
    check("full_recv_msg", 64'(bus.recv_msg), 64'h1111_1111);
    expect_recv(32'h1111_1111, 1'b0);
    bus.recv_rdy = 1'b1;
    wait_clk(4);
    check("drain_recv_val", 64'(bus.recv_val), 64'd0);
    expect_recv(32'h0000_0007, 1'b1);
    expect_miso(1'b0, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_0007, 4);
    wait_clk(6);

    // Short and long frames are discarded
    spi_xfer(40'h01_0000_0000, 33, 4);
    wait_clk(6);
    check("short_parity", 64'(bus.minion_parity), 64'd1);
    check("short_recv_val", 64'(bus.recv_val), 64'd0);
    spi_xfer(40'h06_0000_0001, 35, 4);
    wait_clk(6);
    check("long_parity", 64'(bus.minion_parity), 64'd1);
    check("long_recv_val", 64'(bus.recv_val), 64'd0);

    // Minimum timing: sclk = clk/6, cs high 3 cycles
    expect_recv(32'h0000_0000, 1'b0);
    expect_miso(1'b0, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_0000, 3);
    expect_recv(32'hFFFF_FFFF, 1'b0);
    expect_miso(1'b0, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'hFFFF_FFFF, 3);
    wait_clk(6);
    check("fast_last_msg", 64'(bus.recv_msg), 64'hFFFF_FFFF);
    check("fast_parity", 64'(bus.minion_parity), 64'd0);

    wait_clk(20);
    check("recv_queue_drained", 64'(exp_recv.size()), 64'd0);
    check("send_queue_drained", 64'(exp_send.size()), 64'd0);
    check("miso_queue_drained", 64'(exp_miso.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
